scr1_pipe_sleep_ctrl: RTL

Pipe-side initiator of the sleep/wake protocol that the core clock control block answers. It turns a retired WFI into a drained, gated-clock sleep request. It raises a wake request on interrupt or debug events and holds it until the clock is re-enabled. It runs on the always-on pipe clock and sits in the pipeline beside the CSR/exception logic.

---
 rtl/scr1_pipe_sleep_ctrl_pkg.sv | 14 +
 rtl/scr1_pipe_sleep_ctrl_if.sv | 20 ++
 rtl/scr1_pipe_sleep_ctrl_sat_cnt.sv | 29 ++
 rtl/scr1_pipe_sleep_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/scr1_pipe_sleep_ctrl_pkg.sv
// Shared types and default widths for the pipe sleep/wake controller.
package scr1_pipe_sleep_pkg;

  typedef enum logic [1:0] {
    SCR1_SLP_RUN   = 2'd0,
    SCR1_SLP_DRAIN = 2'd1,
    SCR1_SLP_SLEEP = 2'd2,
    SCR1_SLP_WAKE  = 2'd3
  } type_scr1_slp_fsm_e;

  localparam int SCR1_SLP_DRAIN_TMO_W = 6;
  localparam int SCR1_SLP_CNT_W       = 16;

endpackage

// File: rtl/scr1_pipe_sleep_ctrl_if.sv
// Sleep/wake request handshake between the pipe and clock control.
interface scr1_pipe_sleep_ctrl_if;

  logic pipe2clkctl_sleep_req;
  logic pipe2clkctl_wake_req;
  logic clkctl_clk_en;

  modport master (
    output pipe2clkctl_sleep_req,
    output pipe2clkctl_wake_req,
    input  clkctl_clk_en
  );

  modport slave (
    input  pipe2clkctl_sleep_req,
    input  pipe2clkctl_wake_req,
    output clkctl_clk_en
  );

endinterface

// File: rtl/scr1_pipe_sleep_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear.
module scr1_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;
  logic         w_sat;

  assign w_sat = &r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_sat) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/scr1_pipe_sleep_ctrl.sv
// Turns a retired WFI into a drained sleep request and raises wake
// requests on interrupt/debug until the core clock is back.
module scr1_pipe_sleep_ctrl
  import scr1_pipe_sleep_pkg::*;
#(
  parameter int DRAIN_TMO_W = SCR1_SLP_DRAIN_TMO_W,
  parameter int SLP_CNT_W   = SCR1_SLP_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wfi_start_i,
  input  logic                  pipe_idle_i,
  input  logic                  wake_irq_i,
  input  logic                  wake_dbg_i,
  scr1_pipe_sleep_ctrl_if.master clkctl,
  output logic                  fetch_stall_o,
  output logic                  wfi_done_o,
  output logic                  wfi_aborted_o,
  output logic [SLP_CNT_W-1:0]  slp_cycles_o
);

  // Leave DRAIN in the cycle whose count would reach all-ones.
  localparam logic [DRAIN_TMO_W-1:0] DRAIN_LAST = ~DRAIN_TMO_W'(1);

  type_scr1_slp_fsm_e r_state;
  type_scr1_slp_fsm_e w_state_nxt;

  logic                   w_wake;
  logic                   w_wfi_go;
  logic                   w_drain_tmo;
  logic                   w_slp_inc;
  logic [DRAIN_TMO_W-1:0] w_drain_cnt;

  logic r_sleep_req, w_sleep_req_nxt;
  logic r_wake_req, w_wake_req_nxt;
  logic r_fetch_stall, w_fetch_stall_nxt;
  logic r_wfi_done, w_wfi_done_nxt;
  logic r_wfi_aborted, w_wfi_aborted_nxt;

  assign w_wake      = wake_irq_i | wake_dbg_i;
  assign w_wfi_go    = (r_state == SCR1_SLP_RUN) & wfi_start_i & ~w_wake;
  assign w_drain_tmo = (w_drain_cnt == DRAIN_LAST);
  assign w_slp_inc   = ((r_state == SCR1_SLP_SLEEP) |
                        (r_state == SCR1_SLP_WAKE)) &
                       ~clkctl.clkctl_clk_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SCR1_SLP_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SCR1_SLP_RUN: begin
        if (w_wfi_go) w_state_nxt = SCR1_SLP_DRAIN;
      end
      SCR1_SLP_DRAIN: begin
        if (w_wake)           w_state_nxt = SCR1_SLP_RUN;
        else if (w_drain_tmo) w_state_nxt = SCR1_SLP_RUN;
        else if (pipe_idle_i) w_state_nxt = SCR1_SLP_SLEEP;
      end
      SCR1_SLP_SLEEP: begin
        if (w_wake) w_state_nxt = SCR1_SLP_WAKE;
      end
      SCR1_SLP_WAKE: begin
        if (clkctl.clkctl_clk_en) w_state_nxt = SCR1_SLP_RUN;
      end
      default: w_state_nxt = SCR1_SLP_RUN;
    endcase
  end

  always_comb begin
    w_sleep_req_nxt   = (w_state_nxt == SCR1_SLP_SLEEP);
    w_wake_req_nxt    = (w_state_nxt == SCR1_SLP_WAKE);
    w_fetch_stall_nxt = (w_state_nxt != SCR1_SLP_RUN);
    w_wfi_done_nxt    = 1'b0;
    w_wfi_aborted_nxt = 1'b0;
    if (r_state == SCR1_SLP_RUN) begin
      // WFI with a wake already pending retires as a NOP.
      w_wfi_done_nxt    = wfi_start_i & w_wake;
      w_wfi_aborted_nxt = wfi_start_i & w_wake;
    end else if (w_state_nxt == SCR1_SLP_RUN) begin
      w_wfi_done_nxt    = 1'b1;
      w_wfi_aborted_nxt = (r_state != SCR1_SLP_WAKE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sleep_req   <= 1'b0;
      r_wake_req    <= 1'b0;
      r_fetch_stall <= 1'b0;
      r_wfi_done    <= 1'b0;
      r_wfi_aborted <= 1'b0;
    end else begin
      r_sleep_req   <= w_sleep_req_nxt;
      r_wake_req    <= w_wake_req_nxt;
      r_fetch_stall <= w_fetch_stall_nxt;
      r_wfi_done    <= w_wfi_done_nxt;
      r_wfi_aborted <= w_wfi_aborted_nxt;
    end
  end

  scr1_sat_cnt #(
    .W (DRAIN_TMO_W)
  ) u_drain_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_wfi_go),
    .i_inc (r_state == SCR1_SLP_DRAIN),
    .o_cnt (w_drain_cnt)
  );

  scr1_sat_cnt #(
    .W (SLP_CNT_W)
  ) u_slp_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_wfi_go),
    .i_inc (w_slp_inc),
    .o_cnt (slp_cycles_o)
  );

  assign clkctl.pipe2clkctl_sleep_req = r_sleep_req;
  assign clkctl.pipe2clkctl_wake_req  = r_wake_req;
  assign fetch_stall_o                = r_fetch_stall;
  assign wfi_done_o                   = r_wfi_done;
  assign wfi_aborted_o                = r_wfi_aborted;

endmodule
